lfsr: RTL and testbench

// - Mode-selectable Fibonacci LFSR pseudo-random generator with 8/9/10/11-bit maximal-length polynomials.
// - Start/stop control; output is the live register state, zero-extended to 11 bits.
// - Serves as the pseudo-random source compared against a binary counter of equal width.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_feedback.sv | 23 ++
 rtl/lfsr.sv | 52 +++++
 tb/tb_lfsr.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the mode-selectable Fibonacci LFSR.
// Tap and width masks are looked up per mode; all modes share one 11-bit register.
package lfsr_pkg;

  localparam int              OUT_W = 11;
  localparam logic [OUT_W-1:0] SEED = 11'h001;

  typedef enum logic [1:0] {MODE_8, MODE_9, MODE_10, MODE_11} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  function automatic logic [OUT_W-1:0] tap_mask(input mode_e m);
    case (m)
      MODE_8:  tap_mask = 11'h0B8;
      MODE_9:  tap_mask = 11'h110;
      MODE_10: tap_mask = 11'h240;
      MODE_11: tap_mask = 11'h500;
      default: tap_mask = 11'h0B8;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] width_mask(input mode_e m);
    case (m)
      MODE_8:  width_mask = 11'h0FF;
      MODE_9:  width_mask = 11'h1FF;
      MODE_10: width_mask = 11'h3FF;
      MODE_11: width_mask = 11'h7FF;
      default: width_mask = 11'h0FF;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational next-state for the LFSR: truncate to the active width, then step.
// An all-zero truncated state reloads SEED so the register can never lock up.
module lfsr_feedback
  import lfsr_pkg::*;
(
  input  mode_e            mode,
  input  logic [OUT_W-1:0] cur,
  output logic [OUT_W-1:0] nxt
);

  logic [OUT_W-1:0] wmask;
  logic [OUT_W-1:0] trunc;
  logic             fb;

  always_comb begin
    wmask = width_mask(mode);
    trunc = cur & wmask;
    fb    = ^(trunc & tap_mask(mode));
    if (trunc == '0) nxt = SEED;
    else             nxt = {trunc[OUT_W-2:0], fb} & wmask;
  end

endmodule

// File: rtl/lfsr.sv
// Start/stop controlled LFSR generator: IDLE/RUN/PAUSE FSM around an 11-bit register.
// The output is the live register; the feedback block keeps bits above the active width clear.
module lfsr
  import lfsr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] lfsr_out
);

  state_e           state, state_nxt;
  logic [OUT_W-1:0] val_nxt;
  logic [OUT_W-1:0] step_val;

  lfsr_feedback u_fb (
    .mode (mode_e'(mode)),
    .cur  (lfsr_out),
    .nxt  (step_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr_out <= '0;
    end else begin
      state    <= state_nxt;
      lfsr_out <= val_nxt;
    end
  end

  // stop has priority over start in every state
  always_comb begin
    state_nxt = state;
    val_nxt   = lfsr_out;
    case (state)
      IDLE: if (start && !stop) begin
        state_nxt = RUN;
        val_nxt   = SEED;
      end
      RUN: begin
        if (stop) state_nxt = PAUSE;
        else      val_nxt   = step_val;
      end
      PAUSE: if (!stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr: the stimulus process pushes the expected next output per cycle,
// a separate monitor pops and compares one entry after every rising edge.
module tb_lfsr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [10:0] lfsr_out;

  typedef struct {
    logic [10:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          errors  = 0;

  int          m_st  = 0;      // 0 idle, 1 run, 2 pause
  logic [10:0] m_val = '0;

  lfsr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .lfsr_out (lfsr_out)
  );

  always #5 clk = ~clk;

  // reference step written from the polynomials' tap positions
  function automatic logic [10:0] ref_step(input logic [10:0] s, input logic [1:0] md);
    logic [10:0] wm;
    logic [10:0] t;
    logic        fb;
    case (md)
      2'd0:    begin wm = 11'h0FF; fb = s[7] ^ s[5] ^ s[4] ^ s[3]; end
      2'd1:    begin wm = 11'h1FF; fb = s[8] ^ s[4]; end
      2'd2:    begin wm = 11'h3FF; fb = s[9] ^ s[6]; end
      default: begin wm = 11'h7FF; fb = s[10] ^ s[8]; end
    endcase
    t = s & wm;
    if (t == 11'h000) return 11'h001;
    return ((t << 1) | {10'h0, fb}) & wm;
  endfunction

  // one stimulus cycle; hand value overrides the model's prediction when use_hand is set
  task automatic cyc(input logic r, input logic s, input logic p, input logic [1:0] md,
                     input logic use_hand, input logic [10:0] hand, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r; start = s; stop = p; mode = md;
    if (!r) begin
      m_st = 0; m_val = '0;
    end else begin
      case (m_st)
        0: if (s && !p) begin m_st = 1; m_val = 11'h001; end
        1: if (p) m_st = 2; else m_val = ref_step(m_val, md);
        default: if (!p) m_st = 1;
      endcase
    end
    e.exp  = use_hand ? hand : m_val;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic hv(input logic s, input logic p, input logic [1:0] md,
                    input logic [10:0] hand, input string nm);
    cyc(1'b1, s, p, md, 1'b1, hand, nm);
  endtask

  task automatic mv(input logic [1:0] md, input string nm);
    cyc(1'b1, 1'b0, 1'b0, md, 1'b0, 11'h000, nm);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (lfsr_out !== e.exp) begin
        errors++;
        $display("FAIL %s: lfsr_out=%03h expected %03h", e.name, lfsr_out, e.exp);
      end
    end
  end

  initial begin
    logic [10:0] seq8[8];
    logic [10:0] seq10[10];
    seq8  = '{11'h002, 11'h004, 11'h008, 11'h011, 11'h023, 11'h047, 11'h08E, 11'h01C};
    seq10 = '{11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h081, 11'h102,
              11'h204, 11'h009};

    // reset and idle behaviour
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 11'h000, "reset0");
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 11'h000, "reset1");
    for (int i = 0; i < 3; i++) hv(1'b0, 1'b0, 2'd0, 11'h000, "idle_hold");
    hv(1'b1, 1'b1, 2'd0, 11'h000, "idle_start_stop");

    // 8b run, stop/resume, mode switch to 9b, start while running
    hv(1'b1, 1'b0, 2'd0, 11'h001, "start_seed8");
    for (int i = 0; i < 7; i++) hv(1'b0, 1'b0, 2'd0, seq8[i], "run8");
    hv(1'b0, 1'b1, 2'd0, 11'h08E, "stop_hold0");
    hv(1'b1, 1'b1, 2'd3, 11'h08E, "stop_hold1");
    hv(1'b0, 1'b0, 2'd0, 11'h08E, "resume_hold");
    hv(1'b0, 1'b0, 2'd1, 11'h11C, "sw_8to9");
    hv(1'b0, 1'b0, 2'd1, 11'h038, "run9");
    hv(1'b1, 1'b0, 2'd1, 11'h071, "start_in_run");

    // reset mid-run needs a fresh start
    cyc(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 11'h000, "reset_mid");
    hv(1'b0, 1'b0, 2'd1, 11'h000, "post_reset0");
    hv(1'b0, 1'b0, 2'd1, 11'h000, "post_reset1");

    // full 8b period
    hv(1'b1, 1'b0, 2'd0, 11'h001, "start_p8");
    for (int i = 0; i < 254; i++) mv(2'd0, "period8");
    hv(1'b0, 1'b0, 2'd0, 11'h001, "wrap8");

    // 10b sequence
    cyc(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 11'h000, "reset10");
    hv(1'b1, 1'b0, 2'd2, 11'h001, "start_seed10");
    for (int i = 0; i < 10; i++) hv(1'b0, 1'b0, 2'd2, seq10[i], "run10");

    // 11b sequence, then narrowing to 8b on an all-zero truncation
    cyc(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 11'h000, "reset11");
    hv(1'b1, 1'b0, 2'd3, 11'h001, "start_seed11");
    for (int i = 1; i <= 8; i++) begin
      logic [10:0] p2;
      p2 = 11'h001 << i;
      hv(1'b0, 1'b0, 2'd3, p2, "run11_shift");
    end
    hv(1'b0, 1'b1, 2'd3, 11'h100, "pause11");
    hv(1'b0, 1'b1, 2'd0, 11'h100, "pause_mode_hold");
    hv(1'b0, 1'b0, 2'd0, 11'h100, "resume11");
    hv(1'b0, 1'b0, 2'd0, 11'h001, "sw_11to8_lockup");
    hv(1'b0, 1'b0, 2'd0, 11'h002, "run8_after_sw");

    // 11b taps and full 11b period
    cyc(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 11'h000, "reset11b");
    hv(1'b1, 1'b0, 2'd3, 11'h001, "start_p11");
    for (int i = 0; i < 7; i++) mv(2'd3, "period11_head");
    hv(1'b0, 1'b0, 2'd3, 11'h100, "run11_100");
    hv(1'b0, 1'b0, 2'd3, 11'h201, "run11_201");
    hv(1'b0, 1'b0, 2'd3, 11'h402, "run11_402");
    hv(1'b0, 1'b0, 2'd3, 11'h005, "run11_005");
    for (int i = 0; i < 2046 - 11; i++) mv(2'd3, "period11");
    hv(1'b0, 1'b0, 2'd3, 11'h001, "wrap11");

    // narrowing with non-zero truncation
    hv(1'b0, 1'b0, 2'd0, 11'h002, "sw_11to8");

    begin : drain
      int budget;
      budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (sb_q.size() > 0) begin
        errors++;
        $display("FAIL drain: pending=%0d expected 0", sb_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
